// File: rtl/dmem_responder.sv
// Data-memory slave for the CPU DMEM port: byte-lane store merge, raw 32-bit loads,
// programmable wait states and a one-outstanding valid/ready handshake.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] daddr,
    input  logic [3:0]  dwe,
    input  logic [31:0] dwdata,
    output logic        rsp_valid,
    output logic [31:0] drdata,
    output logic        rsp_err
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be 0..15");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr
        $error("dmem_responder: ADDR_W must be 1..29");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        we_q;
    logic [31:0]       wd_q;
    logic              oor;
    logic              commit;

    // Byte offset bits are irrelevant: lanes are selected by dwe.
    logic unused_addr_bits;
    assign unused_addr_bits = ^daddr[1:0];

    // The access happens on the last WAIT edge; a reset on that same edge cancels it.
    assign commit = (state == S_WAIT) && (cnt == 4'd0) && !reset;

    always_ff @(posedge clk) begin
        if (commit && !oor) begin
            for (int k = 0; k < 4; k++) begin
                if (we_q[k]) mem[idx][8*k +: 8] <= wd_q[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            drdata    <= 32'd0;
            rsp_err   <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    rsp_valid <= 1'b0;
                    drdata    <= 32'd0;
                    rsp_err   <= 1'b0;
                    if (req_valid) begin
                        idx       <= daddr[ADDR_W+1:2];
                        we_q      <= dwe;
                        wd_q      <= dwdata;
                        oor       <= |daddr[31:ADDR_W+2];
                        cnt       <= 4'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= oor;
                        drdata    <= (!oor && we_q == 4'd0) ? mem[idx] : 32'd0;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    drdata    <= 32'd0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    drdata    <= 32'd0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: three responders (0, 3 and 4 wait states) share one request bus and are
// checked against a word-array model with byte-lane merge.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] daddr = '0;
    logic [3:0]  dwe = '0;
    logic [31:0] dwdata = '0;
    logic        rdy [3];
    logic        rv  [3];
    logic        err [3];
    logic [31:0] rd  [3];

    int n_vec = 0;
    int n_mis = 0;

    logic [31:0] mm [0:1023];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_d0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .daddr(daddr), .dwe(dwe), .dwdata(dwdata),
        .rsp_valid(rv[0]), .drdata(rd[0]), .rsp_err(err[0]));
    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_d3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .daddr(daddr), .dwe(dwe), .dwdata(dwdata),
        .rsp_valid(rv[1]), .drdata(rd[1]), .rsp_err(err[1]));
    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(4)) u_d4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
        .daddr(daddr), .dwe(dwe), .dwdata(dwdata),
        .rsp_valid(rv[2]), .drdata(rd[2]), .rsp_err(err[2]));

    function automatic int wc(int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 4);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] we, logic [31:0] wd);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++) begin
            if (we[k]) r = (r & ~(32'hFF << (8*k))) | (wd & (32'hFF << (8*k)));
        end
        return r;
    endfunction

    function automatic logic in_range(logic [31:0] a);
        return a < 32'h1000;
    endfunction

    function automatic void model_store(logic [31:0] a, logic [3:0] we, logic [31:0] wd);
        if (we != 4'd0 && in_range(a)) mm[a[11:2]] = merge(mm[a[11:2]], we, wd);
    endfunction

    // One transfer on the shared bus; every DUT in mask must answer exactly once
    // with latency wait+2 and the expected data. pulse_k>0 injects a stray req_valid.
    task automatic xact(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic [2:0] mask, input int pulse_k, input string nm);
        int          lat [3];
        int          nrsp [3];
        logic        bad [3];
        logic [31:0] got_rd [3];
        logic        got_err [3];
        logic        all_rdy;
        all_rdy = 1'b0;
        for (int t = 0; t < 40; t++) begin
            all_rdy = rdy[0] && rdy[1] && rdy[2];
            if (all_rdy) break;
            @(posedge clk); #1;
        end
        chk({nm, " ready-wait"}, all_rdy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1; nrsp[i] = 0; bad[i] = 1'b0; got_rd[i] = '0; got_err[i] = 1'b0;
        end
        req_valid = 1'b1; daddr = a; dwe = we; dwdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; daddr = $urandom; dwe = 4'($urandom); dwdata = $urandom;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rv[i]) begin
                    nrsp[i]++;
                    if (lat[i] < 0) begin
                        lat[i] = k; got_rd[i] = rd[i]; got_err[i] = err[i];
                    end
                end else if (rd[i] != 32'd0 || err[i]) begin
                    bad[i] = 1'b1;
                end
                if (rdy[i] != (k > wc(i) + 2)) bad[i] = 1'b1;
            end
            req_valid = (k == pulse_k);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                chk($sformatf("%s d%0d latency", nm, i), lat[i], wc(i) + 2);
                chk($sformatf("%s d%0d rsp-count", nm, i), nrsp[i], 1);
                chk($sformatf("%s d%0d drdata", nm, i), got_rd[i], exp_rd);
                chk($sformatf("%s d%0d rsp_err", nm, i), got_err[i], exp_err);
                chk($sformatf("%s d%0d ready/idle-outputs", nm, i), bad[i], 1'b0);
            end
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
        logic        saw;

        tbl[0]  = '{32'h10,       4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{32'h10,       4'b0000, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{32'h10,       4'b0010, 32'h0000AA00, 32'h0,        1'b0};
        tbl[3]  = '{32'h13,       4'b0000, 32'h0,        32'hDEADAAEF, 1'b0};
        tbl[4]  = '{32'h20,       4'b1111, 32'h0,        32'h0,        1'b0};
        tbl[5]  = '{32'h20,       4'b1100, 32'h12340000, 32'h0,        1'b0};
        tbl[6]  = '{32'h20,       4'b0000, 32'h0,        32'h12340000, 1'b0};
        tbl[7]  = '{32'h0,        4'b1111, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[8]  = '{32'h1000,     4'b1111, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[9]  = '{32'h0,        4'b0000, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[10] = '{32'h1000,     4'b0000, 32'h0,        32'h0,        1'b1};
        tbl[11] = '{32'hFFFFFFFC, 4'b0001, 32'h000000AB, 32'h0,        1'b1};
        tbl[12] = '{32'hFFC,      4'b1111, 32'h13579BDF, 32'h0,        1'b0};
        tbl[13] = '{32'hFFE,      4'b0000, 32'h0,        32'h13579BDF, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset d%0d req_ready", i), rdy[i], 1'b1);
            chk($sformatf("reset d%0d rsp_valid", i), rv[i], 1'b0);
            chk($sformatf("reset d%0d drdata", i), rd[i], 32'h0);
            chk($sformatf("reset d%0d rsp_err", i), err[i], 1'b0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 14; v++) begin
            xact(tbl[v].a, tbl[v].we, tbl[v].wd, tbl[v].erd, tbl[v].eerr, 3'b111, 0,
                 $sformatf("tbl%0d", v));
            model_store(tbl[v].a, tbl[v].we, tbl[v].wd);
        end

        // Stray req_valid during the busy window must not start a second access.
        xact(32'h10, 4'b0000, 32'h0, mm[4], 1'b0, 3'b111, 2, "stray-pulse");

        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            xact(32'(w * 4), 4'b1111, wd, 32'h0, 1'b0, 3'b111, 0, $sformatf("init%0d", w));
            model_store(32'(w * 4), 4'b1111, wd);
        end
        for (int n = 0; n < 120; n++) begin
            wd = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                a  = {20'($urandom_range(1, 20'hFFFFF)), 10'($urandom_range(0, 1023)), 2'($urandom)};
                we = 4'($urandom);
                xact(a, we, wd, 32'h0, 1'b1, 3'b111, 0, $sformatf("rnd%0d", n));
            end else begin
                a  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                we = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
                xact(a, we, wd, (we == 4'd0) ? mm[a[11:2]] : 32'h0, 1'b0, 3'b111, 0,
                     $sformatf("rnd%0d", n));
                model_store(a, we, wd);
            end
        end

        // Reset two cycles after accepting a write: only the 0-wait DUT has committed.
        xact(32'h40, 4'b1111, 32'h11111111, 32'h0, 1'b0, 3'b111, 0, "abort-pre");
        model_store(32'h40, 4'b1111, 32'h11111111);
        req_valid = 1'b1; daddr = 32'h40; dwe = 4'b0001; dwdata = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort d0 rsp_valid", rv[0], 1'b1);
        chk("abort d3 rsp_valid", rv[1], 1'b0);
        chk("abort d4 rsp_valid", rv[2], 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("abort d%0d req_ready", i), rdy[i], 1'b1);
        saw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rv[1] || rv[2]) saw = 1'b1;
        end
        chk("abort late rsp_valid", saw, 1'b0);
        @(posedge clk); #1;
        xact(32'h40, 4'b0000, 32'h0, 32'h11111111, 1'b0, 3'b110, 0, "abort-readback");
        xact(32'h40, 4'b0000, 32'h0, merge(32'h11111111, 4'b0001, 32'h55), 1'b0, 3'b001, 0,
             "commit-readback");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
